// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the sequential barrel shifter.
//   state_t        : controller states (IDLE, SHIFT, DONE)
//   DIR_LEFT/RIGHT : encoding of the shift-direction input
//   DEFAULT_WIDTH  : default data width
// Optional feature macro used by the files that import this package:
//   SEQ_BARREL_SHIFTER_ROTATE_EN
// -----------------------------------------------------------------------------
package shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// Combinational single log-step shifter. It moves the data by 2^index in the
// requested direction, or passes it through unchanged when enable is low.
// Right shifts are arithmetic and left shifts are logical.
// Ports:
//   data   in  WIDTH  operand
//   dir    in  1      DIR_LEFT / DIR_RIGHT
//   index  in  IDX_W  log-step number (0 .. AMT_W-1)
//   enable in  1      apply the step when high
//   rot    in  1      rotate instead of shift (SEQ_BARREL_SHIFTER_ROTATE_EN only)
//   result out WIDTH  stepped data
// Macro: SEQ_BARREL_SHIFTER_ROTATE_EN adds the rot input.
// -----------------------------------------------------------------------------
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]                  data,
    input  logic                              dir,
    input  logic [$clog2($clog2(WIDTH))-1:0]  index,
    input  logic                              enable,
`ifdef SEQ_BARREL_SHIFTER_ROTATE_EN
    input  logic                              rot,
`endif
    output logic [WIDTH-1:0]                  result
);

    localparam int AMT_W = $clog2(WIDTH);
    localparam int IDX_W = $clog2(AMT_W);

    // One candidate per log-step. Every distance is a constant, so each
    // candidate is just wiring plus a direction mux.
    logic [WIDTH-1:0] cand [AMT_W];

    genvar gi;
    generate
        for (gi = 0; gi < AMT_W; gi++) begin : g_step
            localparam int S = 1 << gi;
            logic [WIDTH-1:0] shl;
            logic [WIDTH-1:0] shr;

            assign shl = {data[WIDTH-1-S:0], {S{1'b0}}};
            // The sign bit never changes during an arithmetic right shift,
            // so the current MSB is the captured operand's MSB.
            assign shr = {{S{data[WIDTH-1]}}, data[WIDTH-1:S]};

`ifdef SEQ_BARREL_SHIFTER_ROTATE_EN
            logic [WIDTH-1:0] rol;
            logic [WIDTH-1:0] ror;

            assign rol = {data[WIDTH-1-S:0], data[WIDTH-1:WIDTH-S]};
            assign ror = {data[S-1:0], data[WIDTH-1:S]};
            assign cand[gi] = rot ? ((dir == DIR_RIGHT) ? ror : rol)
                                  : ((dir == DIR_RIGHT) ? shr : shl);
`else
            assign cand[gi] = (dir == DIR_RIGHT) ? shr : shl;
`endif
        end
    endgenerate

    always_comb begin
        result = data;
        if (enable) begin
            for (int i = 0; i < AMT_W; i++) begin
                if (index == IDX_W'(i)) begin
                    result = cand[i];
                end
            end
        end
    end

endmodule

// File: rtl/seq_barrel_shifter.sv
// -----------------------------------------------------------------------------
// seq_barrel_shifter
// Multi-cycle barrel shifter. It applies one log-step per clock behind a
// start/busy/done handshake. Right shifts are arithmetic and left shifts are
// logical. The latency is AMT_W+1 cycles from the start edge to done,
// whatever the shift amount.
// Ports:
//   clk     in   1      clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request, sampled in IDLE or DONE only
//   sh_dir  in   1      1 = right (arithmetic), 0 = left (logical)
//   sh_amt  in   AMT_W  shift amount
//   d_in    in   WIDTH  operand
//   sh_rot  in   1      rotate select (SEQ_BARREL_SHIFTER_ROTATE_EN only)
//   busy    out  1      shift in progress
//   done    out  1      one-cycle pulse, d_out valid
//   d_out   out  WIDTH  result, held until the next completion
// Macro: SEQ_BARREL_SHIFTER_ROTATE_EN adds sh_rot and rotate behaviour.
// -----------------------------------------------------------------------------
module seq_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      sh_dir,
    input  logic [$clog2(WIDTH)-1:0]  sh_amt,
    input  logic [WIDTH-1:0]          d_in,
`ifdef SEQ_BARREL_SHIFTER_ROTATE_EN
    input  logic                      sh_rot,
`endif
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH-1:0]          d_out
);

    localparam int AMT_W = $clog2(WIDTH);
    localparam int IDX_W = $clog2(AMT_W);
    localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(AMT_W - 1);

    state_t             state_reg;
    logic [IDX_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   work_reg;
    logic               dir_reg;
    logic [AMT_W-1:0]   amt_reg;
    logic [WIDTH-1:0]   d_out_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   stage_next;
`ifdef SEQ_BARREL_SHIFTER_ROTATE_EN
    logic               rot_reg;
`endif

    shift_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .data   (work_reg),
        .dir    (dir_reg),
        .index  (cnt_reg),
        .enable (amt_reg[cnt_reg]),
`ifdef SEQ_BARREL_SHIFTER_ROTATE_EN
        .rot    (rot_reg),
`endif
        .result (stage_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            work_reg  <= '0;
            dir_reg   <= 1'b0;
            amt_reg   <= '0;
            d_out_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef SEQ_BARREL_SHIFTER_ROTATE_EN
            rot_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                // IDLE and DONE both accept a new request; DONE lasts one
                // cycle, so a held start gives back-to-back operation.
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        work_reg  <= d_in;
                        dir_reg   <= sh_dir;
                        amt_reg   <= sh_amt;
`ifdef SEQ_BARREL_SHIFTER_ROTATE_EN
                        rot_reg   <= sh_rot;
`endif
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                        busy_reg  <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                SHIFT: begin
                    work_reg <= stage_next;
                    if (cnt_reg == LAST_STAGE) begin
                        // d_out is written only here, so it never shows
                        // partial results.
                        d_out_reg <= stage_next;
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + IDX_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign d_out = d_out_reg;

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// -----------------------------------------------------------------------------
// tb_seq_barrel_shifter
// Self-checking bench for seq_barrel_shifter: directed sweeps, random
// operations, handshake corner cases and reset abort, checked against a
// behavioural shift model.
// Macro: SEQ_BARREL_SHIFTER_ROTATE_EN enables the rotate port and its tests.
// -----------------------------------------------------------------------------
module tb_seq_barrel_shifter;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          sh_dir;
    logic [4:0]    sh_amt;
    logic [W-1:0]  d_in;
    logic          sh_rot;
    logic          busy;
    logic          done;
    logic [W-1:0]  d_out;

    int            n_checks;
    int            n_fail;
    logic [W-1:0]  prev_out;

    seq_barrel_shifter #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sh_dir (sh_dir),
        .sh_amt (sh_amt),
        .d_in   (d_in),
`ifdef SEQ_BARREL_SHIFTER_ROTATE_EN
        .sh_rot (sh_rot),
`endif
        .busy   (busy),
        .done   (done),
        .d_out  (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the whole operation in one arithmetic expression.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic dir,
                                           input int amt, input logic rot);
        if (rot) begin
            if (amt == 0) return d;
            if (dir) return (d >> amt) | (d << (W - amt));
            return (d << amt) | (d >> (W - amt));
        end
        if (dir) return W'($signed(d) >>> amt);
        return d << amt;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble the inputs after capture and wait for done.
    task automatic run_op(input logic [W-1:0] d, input logic dir, input logic [4:0] amt,
                          input logic rot, input bit mid_pulse);
        logic [W-1:0] exp;
        int lat;
        exp = model(d, dir, int'(amt), rot);
        @(negedge clk);
        d_in = d; sh_dir = dir; sh_amt = amt; sh_rot = rot; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d_in = $urandom; sh_dir = 1'($urandom); sh_amt = 5'($urandom); sh_rot = 1'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            check("busy_during", {31'b0, busy}, 32'd1);
            check("dout_hold", d_out, prev_out);
            start = (mid_pulse && lat == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", W'(lat), W'(6));
        check("result", d_out, exp);
        check("busy_at_done", {31'b0, busy}, 32'd0);
        prev_out = exp;
        $display("op d=%h dir=%0d amt=%0d rot=%0d -> d_out=%h exp=%h lat=%0d",
                 d, dir, amt, rot, d_out, exp, lat);
        @(negedge clk);
        check("done_pulse", {31'b0, done}, 32'd0);
        check("dout_after", d_out, exp);
        if (mid_pulse) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                check("no_extra_done", {31'b0, done}, 32'd0);
                check("no_extra_busy", {31'b0, busy}, 32'd0);
            end
        end
    endtask

    initial begin
        logic [W-1:0] a_exp;
        logic [W-1:0] b_exp;
        int n;

        n_checks = 0; n_fail = 0; prev_out = '0;
        start = 1'b0; sh_dir = 1'b0; sh_amt = '0; d_in = '0; sh_rot = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dout", d_out, '0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;

        // Directed sweeps over every amount.
        for (int a = 0; a < 32; a++) run_op(32'h8000_0000, 1'b1, 5'(a), 1'b0, 1'b0);
        for (int a = 0; a < 32; a++) run_op(32'h4000_0000, 1'b1, 5'(a), 1'b0, 1'b0);
        for (int a = 0; a < 32; a++) run_op(32'h0000_0001, 1'b0, 5'(a), 1'b0, 1'b0);

        // Random operations.
        for (int i = 0; i < 40; i++) begin
`ifdef SEQ_BARREL_SHIFTER_ROTATE_EN
            run_op($urandom, 1'($urandom), 5'($urandom), 1'($urandom), 1'b0);
`else
            run_op($urandom, 1'($urandom), 5'($urandom), 1'b0, 1'b0);
`endif
        end

        // Start pulsed while busy must be ignored.
        run_op(32'hF0F0_1234, 1'b1, 5'd7, 1'b0, 1'b1);

        // Start held high through done: back-to-back capture.
        a_exp = model(32'h1234_5678, 1'b0, 3, 1'b0);
        b_exp = model(32'h9ABC_DEF0, 1'b1, 9, 1'b0);
        @(negedge clk);
        d_in = 32'h1234_5678; sh_dir = 1'b0; sh_amt = 5'd3; sh_rot = 1'b0; start = 1'b1;
        @(negedge clk);
        d_in = 32'h9ABC_DEF0; sh_dir = 1'b1; sh_amt = 5'd9;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_lat_a", W'(n), W'(6));
        check("b2b_res_a", d_out, a_exp);
        $display("b2b op A -> d_out=%h exp=%h lat=%0d", d_out, a_exp, n);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_rise", {31'b0, busy}, 32'd1);
        check("b2b_done_low", {31'b0, done}, 32'd0);
        check("b2b_hold_a", d_out, a_exp);
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_cadence", W'(n), W'(6));
        check("b2b_res_b", d_out, b_exp);
        $display("b2b op B -> d_out=%h exp=%h cadence=%0d", d_out, b_exp, n);
        prev_out = b_exp;

`ifdef SEQ_BARREL_SHIFTER_ROTATE_EN
        run_op(32'h8000_0001, 1'b0, 5'd4, 1'b1, 1'b0);
        check("rotl_const", d_out, 32'h0000_0018);
        run_op(32'h8000_0001, 1'b1, 5'd1, 1'b1, 1'b0);
        check("rotr_const", d_out, 32'hC000_0000);
`endif

        // Reset in the middle of an operation aborts it.
        run_op(32'h0000_00FF, 1'b0, 5'd8, 1'b0, 1'b0);
        @(negedge clk);
        d_in = 32'hDEAD_BEEF; sh_dir = 1'b0; sh_amt = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_dout", d_out, '0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        $display("reset mid-op -> d_out=%h busy=%0d done=%0d", d_out, busy, done);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prev_out = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", {31'b0, done}, 32'd0);
            check("abort_dout_zero", d_out, '0);
        end

        // Normal operation resumes after the abort.
        run_op(32'hFFFF_0000, 1'b1, 5'd31, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_barrel_shifter.md
# seq_barrel_shifter

Multi-cycle, registered counterpart to the combinational barrel shifter. It is used where a full 32-bit single-cycle shifter is too costly, and as a cycle-accurate reference for it. One log-step stage is applied per clock behind a START/BUSY/DONE handshake. Right shifts are arithmetic (sign-extending); left shifts are logical (zero-filling).

## Interface
- WIDTH, 32, data width; must be a power of two and at least 4.
- AMT_W, $clog2(WIDTH) (5 at default), shift-amount width; derived, not overridden.
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  reset; asynchronous, active-low.
- START  input  1  request; sampled only in IDLE or DONE state.
- SH_DIR  input  1  1 = shift right (arithmetic), 0 = shift left (logical).
- SH_AMT  input  AMT_W  shift amount, 0..WIDTH-1.
- D_IN  input  WIDTH  operand.
- BUSY  output  1  high while a shift is in progress.
- DONE  output  1  one-cycle pulse; D_OUT is valid.
- D_OUT  output  WIDTH  result; holds until the next completion.

## Operation
- State machine: IDLE, SHIFT, DONE.
- IDLE with START=1 at an edge:
  - capture D_IN into the work register, and SH_DIR and SH_AMT into holding registers;
  - stage counter <= 0; go to SHIFT.
- SHIFT, stage counter k = 0..AMT_W-1, one stage per edge:
  - if held SH_AMT[k]=1, shift the work register by 2^k in the held direction; otherwise hold it.
  - Right shift fills with the captured bit WIDTH-1. Left shift fills with 0.
- SHIFT with k = AMT_W-1: load the stage result into D_OUT and go to DONE.
- DONE lasts exactly one cycle.
  - START=1: capture new operands and go to SHIFT (back-to-back; no IDLE gap).
  - START=0: go to IDLE.
- START while in SHIFT is ignored; the inputs are not captured.
- D_IN, SH_DIR and SH_AMT are free to change after the capture edge.
- The result equals the combinational shifter's result for the same inputs:
  - SH_AMT=0 gives D_OUT=D_IN;
  - amounts are not saturated (5-bit range only).
- BUSY = (state == SHIFT). DONE = (state == DONE).

## Timing
- Reset (RST_N low, asynchronous): state=IDLE, counter=0, work/holding registers=0, D_OUT=0, BUSY=0, DONE=0.
- Release reset synchronously to CLK at the system level. The block assumes a clean deassertion.
- START sampled at edge E0:
  - BUSY=1 from E0 through E0+AMT_W;
  - D_OUT updated at edge E0+AMT_W (E0+5 at default);
  - DONE high in the cycle after E0+AMT_W.
- Latency: AMT_W+1 cycles from START edge to DONE. Fixed, independent of SH_AMT.
- Throughput: one result per AMT_W+1 cycles with back-to-back START.
- Reset mid-SHIFT aborts immediately. D_OUT returns to 0 and no DONE is produced.
- D_OUT changes only at a completion edge or on reset. It never shows intermediate values.

## Configuration
- Macro SEQ_BARREL_SHIFTER_ROTATE_EN.
- Defined:
  - adds input SH_ROT (1 bit), captured with the other operands at the START edge;
  - SH_ROT=1 makes each stage rotate in SH_DIR instead of shifting, so bits wrap around and no fill is applied;
  - SH_ROT=0 gives the default behaviour.
- Undefined: no SH_ROT port; shift-only behaviour as above.
- Timing and latency are identical in both builds.

## Structure
- Package shifter_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - direction constants DIR_LEFT=0, DIR_RIGHT=1;
  - default width constant 32.
- Sub-module shift_stage, purely combinational:
  - inputs: data, direction, stage index, enable, and rotate (when configured);
  - output: data shifted or rotated by 2^index, or passed through when enable is 0.
- The top level owns the FSM, counter, holding registers and D_OUT.

## Test plan
- Arithmetic right, negative: D_IN=32'h8000_0000, SH_DIR=1, SH_AMT=0..31.
  - Required D_OUT: upper SH_AMT+1 bits set (e.g. amt 4 -> 32'hF800_0000; amt 31 -> 32'hFFFF_FFFF).
  - DONE exactly 6 cycles after each START.
- Right, positive: D_IN=32'h4000_0000, SH_DIR=1, SH_AMT=0..31.
  - Required D_OUT: 32'h4000_0000 >> amt (amt 30 -> 1, amt 31 -> 0).
- Left: D_IN=32'h0000_0001, SH_DIR=0, SH_AMT=0..31.
  - Required D_OUT: 1 << amt. Amt 31 -> 32'h8000_0000.
- Handshake:
  - START pulsed while BUSY: ignored, single DONE.
  - START held through DONE: next op captured, BUSY rises the following cycle, then 6-cycle cadence.
- Reset mid-op: RST_N low two cycles after START -> D_OUT=0, BUSY=0, and DONE never asserts for the aborted op.
- With SEQ_BARREL_SHIFTER_ROTATE_EN:
  - D_IN=32'h8000_0001, SH_ROT=1, SH_DIR=0, SH_AMT=4 -> 32'h0000_0018;
  - SH_DIR=1, SH_AMT=1 -> 32'hC000_0000.
